// File: rtl/alu_seq.sv
// Sequential ALU: add, subtract, shift-add multiply and restoring divide on WIDTH-bit
// unsigned operands, with an Init/Done handshake and registered result outputs.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Init,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         Select,
  output logic [2*WIDTH-1:0] Sal,
  output logic               Cout,
  output logic               Zero,
  output logic               Err,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_MUL = 2'b10;
  localparam logic [1:0] SEL_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] sal_q, sal_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     shifted;
  logic               qbit;
  logic [2*WIDTH-1:0] res;
  logic [CW-1:0]      lastCnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sal_q    <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      sal_q    <= sal_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Iterative ops run WIDTH steps; add, sub and divide-by-zero take a single idle step.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sal_d    = sal_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    err_d    = err_q;
    sum      = '0;
    diff     = '0;
    shifted  = '0;
    qbit     = 1'b0;
    res      = '0;
    lastCnt  = ((sel_q == SEL_MUL) || ((sel_q == SEL_DIV) && (b_q != '0)))
               ? CW'(WIDTH) : CW'(1);

    case (state_q)
      IDLE: begin
        if (Init) begin
          a_d      = A;
          b_d      = B;
          sel_d    = Select;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, B};
          mplier_d = A;
          rem_d    = '0;
          quo_d    = A;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (cnt_q == lastCnt) begin
          cout_d = 1'b0;
          err_d  = 1'b0;
          case (sel_q)
            SEL_ADD: begin
              sum    = {1'b0, a_q} + {1'b0, b_q};
              res    = {{(WIDTH-1){1'b0}}, sum};
              cout_d = sum[WIDTH];
            end
            SEL_SUB: begin
              diff   = a_q - b_q;
              res    = {{WIDTH{1'b0}}, diff};
              cout_d = (a_q >= b_q);
            end
            SEL_MUL: res = acc_q;
            default: begin
              if (b_q == '0) begin
                res   = {a_q, {WIDTH{1'b1}}};
                err_d = 1'b1;
              end else begin
                res = {rem_q, quo_q};
              end
            end
          endcase
          sal_d   = res;
          zero_d  = (res == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (sel_q == SEL_MUL) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end else if ((sel_q == SEL_DIV) && (b_q != '0)) begin
            shifted = {rem_q, quo_q[WIDTH-1]};
            qbit    = (shifted >= {1'b0, b_q});
            rem_d   = qbit ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], qbit};
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign Sal  = sal_q;
  assign Cout = cout_q;
  assign Zero = zero_q;
  assign Err  = err_q;
  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed WIDTH=4 vectors with literal expectations, plus a WIDTH=8
// back-to-back regression, all tracked cycle by cycle against an arithmetic reference.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] sal;
    logic        cout;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        init4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [1:0]  sel4 = '0;
  logic [7:0]  sal4;
  logic        cout4, zero4, err4, busy4, done4;

  logic        init8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  sel8 = '0;
  logic [15:0] sal8;
  logic        cout8, zero8, err8, busy8, done8;

  int tests = 0;
  int fails = 0;
  int doneCount8 = 0;

  logic        mBusy [2];
  logic        mDone [2];
  int          mLeft [2];
  logic [15:0] mSal  [2];
  logic        mCout [2];
  logic        mZero [2];
  logic        mErr  [2];
  res_t        pend  [2];
  logic        prevDone [2];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) dut4 (
    .Clk(clk), .Rst(rst), .Init(init4), .A(a4), .B(b4), .Select(sel4),
    .Sal(sal4), .Cout(cout4), .Zero(zero4), .Err(err4), .Busy(busy4), .Done(done4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst), .Init(init8), .A(a8), .B(b8), .Select(sel8),
    .Sal(sal8), .Cout(cout8), .Zero(zero8), .Err(err8), .Busy(busy8), .Done(done8)
  );

  function automatic res_t refOp(input int w, input logic [1:0] sel, input int a, input int b);
    res_t r;
    int   s;
    int   mask;
    r    = '0;
    mask = (1 << w) - 1;
    case (sel)
      2'd0: begin
        s      = a + b;
        r.sal  = 16'(s);
        r.cout = ((s >> w) & 1) != 0;
      end
      2'd1: begin
        r.sal  = 16'((a - b) & mask);
        r.cout = (a >= b);
      end
      2'd2: r.sal = 16'(a * b);
      default: begin
        if (b == 0) begin
          r.sal = 16'((a << w) | mask);
          r.err = 1'b1;
        end else begin
          r.sal = 16'(((a % b) << w) | (a / b));
        end
      end
    endcase
    return r;
  endfunction

  function automatic int latencyOf(input int w, input logic [1:0] sel, input int b);
    if (sel == 2'd2 || (sel == 2'd3 && b != 0)) return w + 1;
    return 2;
  endfunction

  task automatic modelStep(input int i, input logic init, input int a, input int b,
                           input logic [1:0] sel, input int w);
    if (mDone[i]) begin
      mDone[i] = 1'b0;
      mBusy[i] = 1'b0;
    end else if (mBusy[i]) begin
      mLeft[i] = mLeft[i] - 1;
      if (mLeft[i] == 0) begin
        mDone[i] = 1'b1;
        mSal[i]  = pend[i].sal;
        mCout[i] = pend[i].cout;
        mErr[i]  = pend[i].err;
        mZero[i] = (pend[i].sal == 16'd0);
      end
    end else if (init) begin
      mBusy[i] = 1'b1;
      pend[i]  = refOp(w, sel, a, b);
      mLeft[i] = latencyOf(w, sel, b);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mBusy[i] = 1'b0;
        mDone[i] = 1'b0;
        mLeft[i] = 0;
        mSal[i]  = '0;
        mCout[i] = 1'b0;
        mZero[i] = 1'b1;
        mErr[i]  = 1'b0;
        pend[i]  = '0;
      end
    end else begin
      modelStep(0, init4, int'(a4), int'(b4), sel4, 4);
      modelStep(1, init8, int'(a8), int'(b8), sel8, 8);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(input string name, input int i, input logic [15:0] sal,
                             input logic cout, input logic zero, input logic err,
                             input logic busy, input logic done);
    checkOutput({name, " sal"},  sal,        mSal[i]);
    checkOutput({name, " cout"}, 16'(cout),  16'(mCout[i]));
    checkOutput({name, " zero"}, 16'(zero),  16'(mZero[i]));
    checkOutput({name, " err"},  16'(err),   16'(mErr[i]));
    checkOutput({name, " busy"}, 16'(busy),  16'(mBusy[i]));
    checkOutput({name, " done"}, 16'(done),  16'(mDone[i]));
    checkOutput({name, " done twice"}, 16'(done & prevDone[i]), 16'd0);
    prevDone[i] = done;
  endtask

  initial begin
    prevDone[0] = 1'b0;
    prevDone[1] = 1'b0;
  end

  always @(negedge clk) begin
    compareInst("w4", 0, {8'h00, sal4}, cout4, zero4, err4, busy4, done4);
    compareInst("w8", 1, sal8, cout8, zero8, err8, busy8, done8);
    if (done8) doneCount8++;
  end

  task automatic applyStimulus(input string name, input logic [1:0] sel, input logic [3:0] a,
                               input logic [3:0] b, input logic [7:0] expSal, input logic expCout,
                               input logic expZero, input logic expErr, input int expLat,
                               input bit pulseMid);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    init4 = 1'b1;
    sel4  = sel;
    a4    = a;
    b4    = b;
    @(posedge clk);
    @(negedge clk);
    init4 = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (pulseMid) begin
        init4 = (c == 1 || c == 2);
        a4    = ~a;
        b4    = b ^ 4'h5;
        sel4  = 2'b00;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done4) got = 1'b1;
    end
    init4 = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: no Done within 30 cycles, expected after %0d", name, expLat);
    end else begin
      checkOutput({name, " latency"}, 16'(n), 16'(expLat));
      checkOutput({name, " sal"},  {8'h00, sal4}, {8'h00, expSal});
      checkOutput({name, " cout"}, 16'(cout4), 16'(expCout));
      checkOutput({name, " zero"}, 16'(zero4), 16'(expZero));
      checkOutput({name, " err"},  16'(err4),  16'(expErr));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset sal",  {8'h00, sal4}, 16'h0000);
    checkOutput("reset zero", 16'(zero4), 16'd1);
    checkOutput("reset busy", 16'(busy4), 16'd0);
    checkOutput("reset done", 16'(done4), 16'd0);
    #2 rst = 1'b0;

    applyStimulus("add F+1", 2'b00, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus("sub 3-5", 2'b01, 4'd3, 4'd5, 8'h0E, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus("sub 5-5", 2'b01, 4'd5, 4'd5, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    applyStimulus("mul F*F", 2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    applyStimulus("div 13/4", 2'b11, 4'd13, 4'd4, 8'h13, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus("div 9/0", 2'b11, 4'd9, 4'd0, 8'h9F, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    applyStimulus("add 0+0", 2'b00, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b0);

    // Abort a multiply two cycles in; nothing of it may survive the reset.
    @(negedge clk);
    init4 = 1'b1;
    sel4  = 2'b10;
    a4    = 4'd7;
    b4    = 4'd9;
    @(posedge clk);
    @(negedge clk);
    init4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort busy", 16'(busy4), 16'd0);
    checkOutput("abort sal",  {8'h00, sal4}, 16'h0000);
    checkOutput("abort done", 16'(done4), 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort no late done", 16'(done4), 16'd0);
    applyStimulus("mul 2*3", 2'b10, 4'd2, 4'd3, 8'h06, 1'b0, 1'b0, 1'b0, 5, 1'b0);

    // WIDTH=8: Init held high with operands changing every cycle.
    @(negedge clk);
    init8 = 1'b1;
    for (int c = 0; c < 700; c++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      sel8 = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    init8 = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("w8 ops completed", 16'(doneCount8 >= 20), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
